// File: rtl/fb_pkg.sv
// Shared constants, state encoding and rectangle record for the framebuffer rectangle writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_pkg;

  localparam int VIDEO_WIDTH           = 640;
  localparam int VIDEO_HEIGHT          = 480;
  localparam int PIXEL_COUNT           = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int PIXEL_ADDRESS_WIDTH   = 20;
  localparam int PALETTE_ADDRESS_WIDTH = 9;

  // Writer FSM encoding; plain constants keep the encoding fixed for older tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLIP = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Rectangle request as latched at acceptance.
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] w;
    logic [8:0] h;
  } rect_t;

endpackage

// File: rtl/fb_rect_clip.sv
// Clips a rectangle against the visible screen: exclusive right/bottom edges plus an empty flag.
// Latency: combinational.
// Backpressure: none; the result is registered by the writer in its CLIP state.
module fb_rect_clip
  import fb_pkg::*;
(
  input  logic [9:0]  rect_x,
  input  logic [8:0]  rect_y,
  input  logic [9:0]  rect_w,
  input  logic [8:0]  rect_h,
  output logic [10:0] xe,
  output logic [10:0] ye,
  output logic        empty
);

  logic [10:0] x_sum;
  logic [10:0] y_sum;

  // 11-bit sums cannot wrap, so saturating to the screen edge is a plain compare.
  always_comb begin
    x_sum = {1'b0, rect_x} + {1'b0, rect_w};
    y_sum = {2'b00, rect_y} + {2'b00, rect_h};
    xe    = (x_sum > 11'(VIDEO_WIDTH))  ? 11'(VIDEO_WIDTH)  : x_sum;
    ye    = (y_sum > 11'(VIDEO_HEIGHT)) ? 11'(VIDEO_HEIGHT) : y_sum;
    empty = (rect_w == 10'd0) || (rect_h == 9'd0) ||
            ({1'b0, rect_x} >= 11'(VIDEO_WIDTH)) ||
            ({2'b00, rect_y} >= 11'(VIDEO_HEIGHT));
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Paints a clipped solid rectangle of one palette index into the image RAM, one pixel per write.
// Latency: start accepted in cycle 0, CLIP in cycle 1, first write in cycle 2, done one cycle after last write.
// Backpressure: grant low freezes the walk with wEn low and addr/dataOut held; start is only seen in IDLE.
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [9:0]                       rect_x,
  input  logic [8:0]                       rect_y,
  input  logic [9:0]                       rect_w,
  input  logic [8:0]                       rect_h,
  input  logic [PALETTE_ADDRESS_WIDTH-1:0] color,
  input  logic                             grant,
  output logic                             busy,
  output logic                             done,
  output logic                             wEn,
  output logic [PIXEL_ADDRESS_WIDTH-1:0]   addr,
  output logic [PALETTE_ADDRESS_WIDTH-1:0] dataOut
);

  logic [1:0]                       state_q,    state_d;
  rect_t                            rect_q,     rect_d;
  logic [PALETTE_ADDRESS_WIDTH-1:0] data_q,     data_d;
  logic [10:0]                      xe_q,       xe_d;
  logic [10:0]                      ye_q,       ye_d;
  logic [9:0]                       cx_q,       cx_d;
  logic [8:0]                       cy_q,       cy_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   row_base_q, row_base_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   addr_q,     addr_d;

  logic [10:0] clip_xe;
  logic [10:0] clip_ye;
  logic        clip_empty;
  logic        x_more;
  logic        y_more;
  logic [PIXEL_ADDRESS_WIDTH-1:0] clip_row_base;
  logic [PIXEL_ADDRESS_WIDTH-1:0] next_row_base;

  // Clip runs off the latched request, so the inputs only matter at acceptance.
  fb_rect_clip u_clip (
    .rect_x (rect_q.x),
    .rect_y (rect_q.y),
    .rect_w (rect_q.w),
    .rect_h (rect_q.h),
    .xe     (clip_xe),
    .ye     (clip_ye),
    .empty  (clip_empty)
  );

  // Walk arithmetic: the single row multiply, the next row base, and end-of-row/column tests.
  always_comb begin
    clip_row_base = PIXEL_ADDRESS_WIDTH'(rect_q.y) * PIXEL_ADDRESS_WIDTH'(VIDEO_WIDTH);
    next_row_base = row_base_q + PIXEL_ADDRESS_WIDTH'(VIDEO_WIDTH);
    x_more        = (({1'b0, cx_q} + 11'd1) < xe_q);
    y_more        = (({2'b00, cy_q} + 11'd1) < ye_q);
  end

  // Next-state logic: accept in IDLE, clip once, then walk row-major on granted cycles.
  always_comb begin
    state_d    = state_q;
    rect_d     = rect_q;
    data_d     = data_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rect_d  = '{x: rect_x, y: rect_y, w: rect_w, h: rect_h};
          data_d  = color;
          state_d = ST_CLIP;
        end
      end
      ST_CLIP: begin
        xe_d = clip_xe;
        ye_d = clip_ye;
        if (clip_empty) begin
          state_d = ST_DONE;
        end else begin
          cx_d       = rect_q.x;
          cy_d       = rect_q.y;
          row_base_d = clip_row_base;
          addr_d     = clip_row_base + PIXEL_ADDRESS_WIDTH'(rect_q.x);
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (grant) begin
          if (x_more) begin
            cx_d   = cx_q + 10'd1;
            addr_d = addr_q + PIXEL_ADDRESS_WIDTH'(1);
          end else if (y_more) begin
            cy_d       = cy_q + 9'd1;
            cx_d       = rect_q.x;
            row_base_d = next_row_base;
            addr_d     = next_row_base + PIXEL_ADDRESS_WIDTH'(rect_q.x);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any walk in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rect_q     <= '0;
      data_q     <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      rect_q     <= rect_d;
      data_q     <= data_d;
      xe_q       <= xe_d;
      ye_q       <= ye_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

  // Outputs: status decoded from state, write enable follows grant only while filling.
  always_comb begin
    busy    = (state_q == ST_CLIP) || (state_q == ST_FILL);
    done    = (state_q == ST_DONE);
    wEn     = (state_q == ST_FILL) && grant;
    addr    = addr_q;
    dataOut = data_q;
  end

endmodule
